// File: rtl/niu_pc_unit.sv
// Niu32 program counter: load/increment/branch, circular return-address stack, tri-state bus drive.
// Optional NIU_PC_MISALIGN_TRAP_EN: misaligned PC targets are replaced by TRAP_VECTOR.
module niu_pc_unit #(
   parameter int unsigned WORD_SIZE = 32,
   parameter int unsigned INSTR_SIZE = 4,
   parameter int unsigned IMM_SIZE = 17,
   parameter logic [WORD_SIZE-1:0] PC_STARTLOC = '0,
   parameter int unsigned RAS_DEPTH = 8,
   parameter logic [WORD_SIZE-1:0] TRAP_VECTOR = WORD_SIZE'(32'h4)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 ld_pc,
   input  logic                 inc_pc,
   input  logic                 br_take,
   input  logic [IMM_SIZE-1:0]  br_imm,
   input  logic                 ras_push,
   input  logic                 ras_pop,
   input  logic                 dr_pc,
   input  logic [WORD_SIZE-1:0] bus_in,
   output tri logic [WORD_SIZE-1:0] bus,
   output logic [WORD_SIZE-1:0] pc,
   output logic                 ras_empty,
   output logic                 ras_full,
   output logic                 ras_overflow,
   output logic                 misalign
);

`ifdef NIU_PC_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   localparam int unsigned SHIFT = $clog2(INSTR_SIZE);
   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [WORD_SIZE-1:0] STEP = WORD_SIZE'(INSTR_SIZE);
   localparam logic [WORD_SIZE-1:0] ALIGN_MASK = WORD_SIZE'(INSTR_SIZE - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

   logic [WORD_SIZE-1:0] pc_q, pc_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;
   logic                 mis_q, mis_d;
   logic [WORD_SIZE-1:0] ras_mem [RAS_DEPTH];

   logic                 wr_en;
   logic [PTR_W-1:0]     wr_idx;
   logic [PTR_W-1:0]     top_idx;
   logic [WORD_SIZE-1:0] pc_inc, pc_br, target;
   logic signed [WORD_SIZE-1:0] imm_sext;
   logic                 pop_ok, tgt_chk;

   assign top_idx   = ptr_q - PTR_W'(1);
   assign pc_inc    = pc_q + STEP;
   assign imm_sext  = WORD_SIZE'($signed(br_imm));
   assign pc_br     = pc_q + WORD_SIZE'(imm_sext <<< SHIFT);
   assign ras_empty = (cnt_q == '0);
   assign ras_full  = (cnt_q == CNT_MAX);
   assign pop_ok    = ras_pop && !ras_empty;

   always_comb begin
      pc_d    = pc_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      mis_d   = mis_q;
      wr_en   = 1'b0;
      wr_idx  = ptr_q;
      target  = pc_q;
      tgt_chk = 1'b0;

      if (pop_ok) begin
         target  = ras_mem[top_idx];
         tgt_chk = 1'b1;
      end else if (ld_pc) begin
         target  = bus_in;
         tgt_chk = 1'b1;
      end else if (br_take) begin
         target  = pc_br;
         tgt_chk = 1'b1;
      end else if (inc_pc) begin
         target  = pc_inc;
      end

      if (tgt_chk && ((target & ALIGN_MASK) != '0)) begin
         mis_d = 1'b1;
         if (TRAP_EN) target = TRAP_VECTOR;
      end

      // Push+pop reuses the popped slot, so pointer and count stay put.
      if (ras_push && pop_ok) begin
         wr_en  = 1'b1;
         wr_idx = top_idx;
      end else if (ras_push) begin
         wr_en = 1'b1;
         ptr_d = ptr_q + PTR_W'(1);
         if (ras_full) ovf_d = 1'b1;
         else          cnt_d = cnt_q + CNT_W'(1);
      end else if (pop_ok) begin
         ptr_d = top_idx;
         cnt_d = cnt_q - CNT_W'(1);
      end

      pc_d = target;

      if (stall) begin
         pc_d  = pc_q;
         ptr_d = ptr_q;
         cnt_d = cnt_q;
         ovf_d = ovf_q;
         mis_d = mis_q;
         wr_en = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q  <= PC_STARTLOC;
         ptr_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         mis_q <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
      end else begin
         pc_q  <= pc_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         mis_q <= mis_d;
         if (wr_en) ras_mem[wr_idx] <= pc_inc;
      end
   end

   assign pc           = pc_q;
   assign ras_overflow = ovf_q;
   assign misalign     = mis_q;
   assign bus          = (reset && dr_pc) ? pc_q : 'z;

endmodule

// File: tb/tb_niu_pc_unit.sv
// Self-checking bench for niu_pc_unit: directed steps plus random traffic against a queue-based model.
module tb_niu_pc_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        ld_pc = 1'b0;
   logic        inc_pc = 1'b0;
   logic        br_take = 1'b0;
   logic [16:0] br_imm = '0;
   logic        ras_push = 1'b0;
   logic        ras_pop = 1'b0;
   logic        dr_pc = 1'b0;
   logic [31:0] bus_in = '0;
   tri1  [31:0] bus;
   logic [31:0] pc;
   logic        ras_empty, ras_full, ras_overflow, misalign;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_pc;
   logic [31:0] m_ras[$];
   logic        m_ovf, m_mis;

   niu_pc_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .ld_pc(ld_pc), .inc_pc(inc_pc),
      .br_take(br_take), .br_imm(br_imm), .ras_push(ras_push), .ras_pop(ras_pop),
      .dr_pc(dr_pc), .bus_in(bus_in), .bus(bus), .pc(pc), .ras_empty(ras_empty),
      .ras_full(ras_full), .ras_overflow(ras_overflow), .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, " pc"}, pc, m_pc);
      chk({tag, " empty"}, 32'(ras_empty), 32'(m_ras.size() == 0));
      chk({tag, " full"}, 32'(ras_full), 32'(m_ras.size() == 8));
      chk({tag, " ovf"}, 32'(ras_overflow), 32'(m_ovf));
      chk({tag, " mis"}, 32'(misalign), 32'(m_mis));
      // Undriven bus floats to all ones through the tri1 net.
      chk({tag, " bus"}, bus, (dr_pc && reset) ? m_pc : 32'hFFFF_FFFF);
   endtask

   task automatic model_reset();
      m_pc = 32'h0;
      m_ras.delete();
      m_ovf = 1'b0;
      m_mis = 1'b0;
   endtask

   task automatic model_step();
      logic [31:0] link, tgt;
      int          off;
      bit          popok, tchk;
      if (stall) return;
      link  = m_pc + 32'd4;
      popok = ras_pop && (m_ras.size() > 0);
      tchk  = 1'b1;
      off   = int'($signed(br_imm));
      if (popok)        tgt = m_ras[m_ras.size() - 1];
      else if (ld_pc)   tgt = bus_in;
      else if (br_take) tgt = m_pc + 32'(off * 4);
      else begin
         tchk = 1'b0;
         tgt  = inc_pc ? m_pc + 32'd4 : m_pc;
      end
      if (tchk && (tgt % 4 != 0)) begin
         m_mis = 1'b1;
`ifdef NIU_PC_MISALIGN_TRAP_EN
         tgt = 32'h4;
`endif
      end
      if (ras_push && popok) m_ras[m_ras.size() - 1] = link;
      else if (ras_push) begin
         m_ras.push_back(link);
         if (m_ras.size() > 8) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
         end
      end else if (popok) void'(m_ras.pop_back());
      m_pc = tgt;
   endtask

   task automatic cyc(input string tag, input bit st, input bit ld, input bit inc, input bit br,
                      input bit push, input bit pop, input logic [31:0] bin,
                      input logic [16:0] imm);
      stall = st; ld_pc = ld; inc_pc = inc; br_take = br;
      ras_push = push; ras_pop = pop; bus_in = bin; br_imm = imm;
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
      stall = 0; ld_pc = 0; inc_pc = 0; br_take = 0; ras_push = 0; ras_pop = 0;
   endtask

   initial begin
      model_reset();
      dr_pc = 1'b1;
      #12;
      check_all("reset");
      dr_pc = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_all("release");

      // Increment walk, then drive the bus
      for (int i = 0; i < 3; i++) cyc("inc", 0, 0, 1, 0, 0, 0, 0, 0);
      chk("inc12", pc, 32'd12);
      dr_pc = 1'b1; #1;
      chk("bus12", bus, 32'd12);
      dr_pc = 1'b0; #1;
      chk("busz", bus, 32'hFFFF_FFFF);

      // Branches
      cyc("ld100", 0, 1, 0, 0, 0, 0, 32'h100, 0);
      cyc("brneg", 0, 0, 0, 1, 0, 0, 0, 17'h1FFFE);
      chk("brneg_abs", pc, 32'hF8);
      cyc("ld100b", 0, 1, 0, 0, 0, 0, 32'h100, 0);
      cyc("brpos", 0, 0, 0, 1, 0, 0, 0, 17'h0FFFF);
      chk("brpos_abs", pc, 32'h400FC);

      // Three pushes, three pops, one ignored pop
      for (int i = 1; i <= 3; i++) begin
         cyc("ldp", 0, 1, 0, 0, 0, 0, 32'(i * 16), 0);
         cyc("push", 0, 0, 0, 0, 1, 0, 0, 0);
      end
      cyc("pop1", 0, 0, 0, 0, 0, 1, 0, 0);
      chk("pop1_abs", pc, 32'h34);
      cyc("pop2", 0, 0, 0, 0, 0, 1, 0, 0);
      chk("pop2_abs", pc, 32'h24);
      cyc("pop3", 0, 0, 0, 0, 0, 1, 0, 0);
      chk("pop3_abs", pc, 32'h14);
      cyc("pop4", 0, 0, 0, 0, 0, 1, 0, 0);
      chk("pop4_abs", pc, 32'h14);
      chk("pop4_empty", 32'(ras_empty), 32'd1);

      // Push+pop on empty stack, then on non-empty
      cyc("pp_empty", 0, 0, 1, 0, 1, 1, 0, 0);
      cyc("pp_full", 0, 0, 0, 0, 1, 1, 0, 0);
      cyc("pp_drain", 0, 0, 0, 0, 0, 1, 0, 0);

      // Overflow: nine pushes with moving pc, then eight pops
      for (int i = 0; i < 9; i++) cyc("push9", 0, 0, 1, 0, 1, 0, 0, 0);
      chk("ovf_full", 32'(ras_full), 32'd1);
      chk("ovf_flag", 32'(ras_overflow), 32'd1);
      for (int i = 0; i < 8; i++) cyc("pop8", 0, 0, 0, 0, 0, 1, 0, 0);
      chk("pop8_empty", 32'(ras_empty), 32'd1);

      // Priority and stall
      cyc("ldinc", 0, 1, 1, 0, 0, 0, 32'h200, 0);
      chk("ldinc_abs", pc, 32'h200);
      cyc("stall", 1, 1, 1, 0, 1, 0, 32'h300, 0);
      chk("stall_abs", pc, 32'h200);

      // Misaligned load
      cyc("mis", 0, 1, 0, 0, 0, 0, 32'h203, 0);
`ifdef NIU_PC_MISALIGN_TRAP_EN
      chk("mis_abs", pc, 32'h4);
`else
      chk("mis_abs", pc, 32'h203);
`endif
      chk("mis_flag", 32'(misalign), 32'd1);

      // Random traffic
      cyc("realign", 0, 1, 0, 0, 0, 0, 32'h1000, 0);
      for (int i = 0; i < 400; i++) begin
         logic [31:0] b;
         b = $urandom();
         if ($urandom_range(0, 9) != 0) b[1:0] = 2'b00;
         dr_pc = 1'($urandom_range(0, 1));
         cyc("rand", $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, b, 17'($urandom()));
      end

      // Asynchronous reset mid-operation
      dr_pc = 1'b1; ras_push = 1'b1; inc_pc = 1'b1;
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_all("areset");
      @(posedge clk); #1;
      check_all("areset_hold");
      ras_push = 1'b0; inc_pc = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      cyc("post_reset", 0, 0, 1, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/niu_pc_unit.md
Name: niu_pc_unit

Overview:
- Parametrised successor to the Niu32 multicycle program counter.
- Holds the PC with load, increment and PC-relative branch modes, plus a stall input.
- Adds a circular return-address stack (RAS) for JAL/return, and a tri-state drive of the PC onto the shared datapath bus.
- Sits between the multicycle control FSM and the shared bus; all control inputs are single-cycle strobes from the FSM.

Parameters:
- WORD_SIZE, 32, PC/bus width in bits
- INSTR_SIZE, 4, bytes added per increment; power of two
- IMM_SIZE, 17, width of the branch immediate (signed, in instructions)
- PC_STARTLOC, 32'h0, PC value after reset
- RAS_DEPTH, 8, return-address stack entries; power of two, >=2
- TRAP_VECTOR, 32'h4, PC loaded on a misaligned target (optional feature only)

Ports:
- clk, in, 1, rising-edge clock
- reset, in, 1, asynchronous, active-low reset
- stall, in, 1, freezes all state updates this cycle
- ld_pc, in, 1, load PC from bus_in
- inc_pc, in, 1, PC <= PC + INSTR_SIZE
- br_take, in, 1, PC <= PC + sext(br_imm)*INSTR_SIZE
- br_imm, in, IMM_SIZE, signed branch offset
- ras_push, in, 1, push PC+INSTR_SIZE (JAL link)
- ras_pop, in, 1, PC <= top of RAS, then pop
- dr_pc, in, 1, drive PC onto bus
- bus_in, in, WORD_SIZE, bus value sampled on ld_pc
- bus, out (tri), WORD_SIZE, PC when dr_pc=1, else high-Z
- pc, out, WORD_SIZE, current PC
- ras_empty, out, 1, RAS has zero valid entries
- ras_full, out, 1, RAS holds RAS_DEPTH entries
- ras_overflow, out, 1, sticky; set when a push overwrites the oldest entry
- misalign, out, 1, sticky; PC target not INSTR_SIZE-aligned

Behaviour:
- Reset (reset=0, async): pc=PC_STARTLOC, RAS count=0, pointer=0, ras_empty=1, ras_full=0, ras_overflow=0, misalign=0. The bus is high-Z while reset is asserted, regardless of dr_pc.
- All updates happen on the rising clk edge and are visible the next cycle; latency is 1.
- stall=1: no register changes. bus drive remains combinational on dr_pc.
- PC source priority: ras_pop (if not empty) > ld_pc > br_take > inc_pc > hold.
- Branch arithmetic: sign-extend br_imm to WORD_SIZE, shift left by log2(INSTR_SIZE), add to the current PC, wrap modulo 2^WORD_SIZE.
- Increment wraps modulo 2^WORD_SIZE; 32'hFFFFFFFC + 4 = 0.
- ras_push stores the current pc + INSTR_SIZE (wrapped) at the pointer, increments the pointer mod RAS_DEPTH, and increments count saturating at RAS_DEPTH.
  - Push while full overwrites the oldest entry and sets ras_overflow. Count stays at RAS_DEPTH.
- ras_pop while not empty: pc <= top entry, pointer decrements, count decrements.
- ras_pop while empty: ignored; PC falls through to the next priority source.
- ras_push and ras_pop in the same cycle:
  - The pop target is the old top.
  - The push then writes pc+INSTR_SIZE into the same slot.
  - Net pointer and count are unchanged.
  - If the stack is empty, only the push takes effect.
- misalign sets when any loaded PC value (ld_pc, br, pop) has low log2(INSTR_SIZE) bits nonzero. It is cleared only by reset.
- Reset asserted mid-operation aborts any update; no partial RAS write.

Optional Feature:
- Macro: NIU_PC_MISALIGN_TRAP_EN.
- Defined: when a selected PC target is misaligned, pc <= TRAP_VECTOR instead of the target, and misalign is set.
- Undefined: the misaligned target is loaded as-is and only the misalign flag is set.

Test Plan:
- Reset release, then inc_pc for 3 cycles -> pc = 0, 4, 8, 12. bus = 12 only while dr_pc=1, otherwise Z.
- pc=32'h100, br_take with br_imm=-2 -> pc=32'hF8. With br_imm=17'h0FFFF (+65535) -> pc=32'h100+32'h3FFFC.
- Push at pc=0x10, 0x20, 0x30, then pop x3 -> pc=0x34, 0x24, 0x14. A 4th pop is ignored and ras_empty=1.
- RAS_DEPTH=8: 9 pushes -> ras_full=1, ras_overflow=1. 8 pops return the last 8 links; the first link is lost.
- ld_pc and inc_pc together with bus_in=0x200 -> pc=0x200. Same with stall=1 -> pc unchanged.
- ld_pc with bus_in=0x203 -> misalign=1. pc=0x203 without the macro; pc=TRAP_VECTOR with NIU_PC_MISALIGN_TRAP_EN.
